dec_stage_p: RTL

- Parametrised, registered successor of the decode stage. Accepts one fetched instruction per cycle over a valid/ready handshake. Decodes control, reads the register file and generates the immediate.
- Presents the result in an ID/EX pipeline register with its own valid/ready handshake.
- Adds load-use hazard stalling, flush, an optional write-back bypass and configurable datapath width and register count.
- Sits between the fetch stage and the execute stage.

---
 rtl/dec_pkg.sv | 59 +++++
 rtl/dec_ctrl.sv | 87 ++++++++
 rtl/regfile_p.sv | 37 +++
 rtl/dec_stage_p.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types and helpers for the registered decode stage: control struct,
// MIPS opcode/funct codes, destination-select encoding and immediate extenders.
package dec_pkg;

  typedef struct packed {
    logic       Branch;
    logic       Jump;
    logic       RegJump;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       MULOp;
    logic       ACCEn;
    logic       ALUEn;
    logic       MULSelB;
    logic       ALUSrc;
    logic       RegWrite;
    logic [5:0] ALUfunc;
    logic [2:0] Memfunc;
    logic [2:0] BrCode;
    logic [1:0] OutSel;
  } ctrl_t;

  typedef enum logic [1:0] {
    RD_RT   = 2'b00,
    RD_RD   = 2'b01,
    RD_LINK = 2'b10
  } regdst_t;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL   = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_BLEZ  = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                         OP_ADDIU = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI  = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e,
                         OP_LUI   = 6'h0f, OP_LB     = 6'h20, OP_LH    = 6'h21,
                         OP_LW    = 6'h23, OP_LBU    = 6'h24, OP_LHU   = 6'h25,
                         OP_SB    = 6'h28, OP_SH     = 6'h29, OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR   = 6'h08, FN_JALR  = 6'h09, FN_MFHI = 6'h10,
                         FN_MFLO = 6'h12, FN_MULT  = 6'h18, FN_MULTU = 6'h19,
                         FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUBU = 6'h23,
                         FN_OR   = 6'h25, FN_SLT   = 6'h2a, FN_SLTU = 6'h2b;

  // Extenders produce the widest datapath; callers size-cast down to XLEN.
  localparam int MAXLEN = 64;

  function automatic logic [MAXLEN-1:0] sign_ext(input logic [31:0] v, input int w);
    logic [MAXLEN-1:0] r;
    for (int i = 0; i < MAXLEN; i++) r[i] = (i < w) ? v[5'(i)] : v[5'(w - 1)];
    return r;
  endfunction

  function automatic logic [MAXLEN-1:0] zero_ext(input logic [31:0] v, input int w);
    logic [MAXLEN-1:0] r;
    for (int i = 0; i < MAXLEN; i++) r[i] = (i < w) ? v[5'(i)] : 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/dec_ctrl.sv
// Combinational MIPS control decoder: opcode/funct to control struct plus the
// immediate-kind, destination-select and rt-usage flags the decode stage needs.
module dec_ctrl
  import dec_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] fn,
  input  logic       rt_lsb,
  output ctrl_t      ctrl,
  output regdst_t    reg_dst,
  output logic       zero_imm,
  output logic       jump_imm,
  output logic       lui_imm,
  output logic       unsigned_imm,
  output logic       reads_rt
);

  always_comb begin
    ctrl         = '0;
    reg_dst      = RD_RT;
    zero_imm     = 1'b0;
    jump_imm     = 1'b0;
    lui_imm      = 1'b0;
    unsigned_imm = 1'b0;
    reads_rt     = 1'b0;
    case (op)
      OP_RTYPE: begin
        reads_rt      = 1'b1;
        reg_dst       = RD_RD;
        ctrl.ALUEn    = 1'b1;
        ctrl.RegWrite = 1'b1;
        ctrl.ALUfunc  = fn;
        case (fn)
          FN_JR:   begin ctrl.Jump = 1'b1; ctrl.RegJump = 1'b1; ctrl.ALUEn = 1'b0; ctrl.RegWrite = 1'b0; end
          FN_JALR: begin ctrl.Jump = 1'b1; ctrl.RegJump = 1'b1; ctrl.ALUEn = 1'b0; ctrl.OutSel = 2'd3; end
          FN_MULT, FN_MULTU: begin
            ctrl.MULOp = 1'b1; ctrl.ACCEn = 1'b1; ctrl.MULSelB = 1'b1;
            ctrl.ALUEn = 1'b0; ctrl.RegWrite = 1'b0;
          end
          FN_MFHI, FN_MFLO: begin ctrl.ALUEn = 1'b0; ctrl.OutSel = 2'd2; end
          default: ;
        endcase
      end
      // Compare-against-zero branches take a zero B operand.
      OP_REGIMM, OP_BLEZ, OP_BGTZ: begin
        ctrl.Branch  = 1'b1;
        ctrl.ALUfunc = FN_SUBU;
        ctrl.BrCode  = (op == OP_REGIMM) ? {2'b00, rt_lsb} : op[2:0];
        zero_imm     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        ctrl.Branch  = 1'b1;
        ctrl.ALUfunc = FN_SUBU;
        ctrl.BrCode  = op[2:0];
        reads_rt     = 1'b1;
      end
      OP_J:   begin ctrl.Jump = 1'b1; jump_imm = 1'b1; end
      OP_JAL: begin
        ctrl.Jump = 1'b1; ctrl.RegWrite = 1'b1; ctrl.OutSel = 2'd3;
        jump_imm  = 1'b1; reg_dst = RD_LINK;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
        ctrl.ALUEn = 1'b1; ctrl.ALUSrc = 1'b1; ctrl.RegWrite = 1'b1;
        case (op)
          OP_ADDI:  ctrl.ALUfunc = FN_ADD;
          OP_ADDIU: ctrl.ALUfunc = FN_ADDU;
          OP_SLTI:  ctrl.ALUfunc = FN_SLT;
          OP_SLTIU: ctrl.ALUfunc = FN_SLTU;
          OP_LUI:   begin ctrl.ALUfunc = FN_OR; lui_imm = 1'b1; end
          default:  begin ctrl.ALUfunc = {3'b100, op[2:0]}; unsigned_imm = 1'b1; end
        endcase
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.MemRead = 1'b1; ctrl.MemtoReg = 1'b1; ctrl.RegWrite = 1'b1;
        ctrl.ALUEn   = 1'b1; ctrl.ALUSrc   = 1'b1; ctrl.ALUfunc  = FN_ADDU;
        ctrl.Memfunc = op[2:0]; ctrl.OutSel = 2'd1;
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.MemWrite = 1'b1; ctrl.ALUEn = 1'b1; ctrl.ALUSrc = 1'b1;
        ctrl.ALUfunc  = FN_ADDU; ctrl.Memfunc = op[2:0];
        reads_rt      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/regfile_p.sv
// Two-read, one-write register file with r0 hard-wired to zero.
// Build option DEC_BYPASS_EN forwards same-cycle write-back data to the reads.
module regfile_p #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int RAW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_en,
  input  logic [RAW-1:0]  wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic [RAW-1:0]  a_addr,
  output logic [XLEN-1:0] a_data,
  input  logic [RAW-1:0]  b_addr,
  output logic [XLEN-1:0] b_data
);

  logic [XLEN-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

`ifdef DEC_BYPASS_EN
  assign a_data = (a_addr == '0) ? '0 : (wb_en && wb_addr == a_addr) ? wb_data : regs[a_addr];
  assign b_data = (b_addr == '0) ? '0 : (wb_en && wb_addr == b_addr) ? wb_data : regs[b_addr];
`else
  assign a_data = (a_addr == '0) ? '0 : regs[a_addr];
  assign b_data = (b_addr == '0) ? '0 : regs[b_addr];
`endif

endmodule

// File: rtl/dec_stage_p.sv
// Registered decode stage with load-use stall, flush and ID/EX handshake.
// Build option DEC_BYPASS_EN enables write-back to operand bypass in regfile_p.
module dec_stage_p
  import dec_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREGS   = 32,
  parameter int LINKREG = NREGS - 1,
  localparam int RAW    = $clog2(NREGS)
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instruction,
  input  logic [XLEN-1:0] PCIn,
  input  logic            Flush,
  input  logic            WbEn,
  input  logic [RAW-1:0]  WbAddr,
  input  logic [XLEN-1:0] WbData,
  output logic            OutValid,
  input  logic            OutReady,
  output ctrl_t           OutCtrl,
  output logic [XLEN-1:0] OutRsData,
  output logic [XLEN-1:0] OutRtData,
  output logic [XLEN-1:0] OutImm,
  output logic [RAW-1:0]  OutRdAddr,
  output logic [RAW-1:0]  OutRsAddr,
  output logic [RAW-1:0]  OutRtAddr,
  output logic [4:0]      OutShamt,
  output logic [XLEN-1:0] OutPC,
  output logic [15:0]     StallCnt
);

  logic [RAW-1:0]  rs_addr, rt_addr, rd_sel;
  logic [XLEN-1:0] rs_data, rt_data, imm;
  ctrl_t           ctrl_dec, ctrl_in;
  regdst_t         reg_dst;
  logic            zero_imm, jump_imm, lui_imm, unsigned_imm, reads_rt;
  logic            hazard, accept, load, bubble;

  logic            vld_p1;
  ctrl_t           ctrl_p1;
  logic [XLEN-1:0] rs_data_p1, rt_data_p1, imm_p1, pc_p1;
  logic [RAW-1:0]  rd_p1, rs_p1, rt_p1;
  logic [4:0]      shamt_p1;
  logic [15:0]     stall_cnt;

  assign rs_addr = Instruction[21 +: RAW];
  assign rt_addr = Instruction[16 +: RAW];

  dec_ctrl u_ctrl (
    .op           (Instruction[31:26]),
    .fn           (Instruction[5:0]),
    .rt_lsb       (Instruction[16]),
    .ctrl         (ctrl_dec),
    .reg_dst      (reg_dst),
    .zero_imm     (zero_imm),
    .jump_imm     (jump_imm),
    .lui_imm      (lui_imm),
    .unsigned_imm (unsigned_imm),
    .reads_rt     (reads_rt)
  );

  regfile_p #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk     (Clock),
    .rst     (Reset),
    .wb_en   (WbEn),
    .wb_addr (WbAddr),
    .wb_data (WbData),
    .a_addr  (rs_addr),
    .a_data  (rs_data),
    .b_addr  (rt_addr),
    .b_data  (rt_data)
  );

  always_comb begin
    ctrl_in        = ctrl_dec;
    ctrl_in.ALUSrc = ctrl_dec.ALUSrc | zero_imm;
  end

  always_comb begin
    if (zero_imm)          imm = '0;
    else if (jump_imm)     imm = XLEN'(zero_ext({6'b0, Instruction[25:0]}, 26));
    else if (lui_imm)      imm = XLEN'(sign_ext({Instruction[15:0], 16'b0}, 32));
    else if (unsigned_imm) imm = XLEN'(zero_ext({16'b0, Instruction[15:0]}, 16));
    else                   imm = XLEN'(sign_ext({16'b0, Instruction[15:0]}, 16));
  end

  always_comb begin
    case (reg_dst)
      RD_RT:   rd_sel = rt_addr;
      RD_RD:   rd_sel = Instruction[11 +: RAW];
      default: rd_sel = RAW'(LINKREG);
    endcase
  end

  // A load still in ID/EX cannot yet supply a dependent instruction's operand.
  assign hazard = vld_p1 & ctrl_p1.MemRead & (rd_p1 != '0) &
                  ((rd_p1 == rs_addr) | ((rd_p1 == rt_addr) & reads_rt));
  assign load    = ~vld_p1 | OutReady;
  assign InReady = ~Flush & ~hazard & load;
  assign accept  = InValid & InReady;
  assign bubble  = hazard & InValid & OutReady & ~Flush;

  // ID/EX boundary
  always_ff @(posedge Clock) begin
    if (Reset) begin
      vld_p1     <= 1'b0;
      ctrl_p1    <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      pc_p1      <= '0;
      rd_p1      <= '0;
      rs_p1      <= '0;
      rt_p1      <= '0;
      shamt_p1   <= '0;
      stall_cnt  <= '0;
    end else begin
      if (Flush) begin
        vld_p1 <= 1'b0;
      end else if (load) begin
        vld_p1 <= accept;
        if (accept) begin
          ctrl_p1    <= ctrl_in;
          rs_data_p1 <= rs_data;
          rt_data_p1 <= rt_data;
          imm_p1     <= imm;
          pc_p1      <= PCIn;
          rd_p1      <= rd_sel;
          rs_p1      <= rs_addr;
          rt_p1      <= rt_addr;
          shamt_p1   <= Instruction[10:6];
        end
      end
      if (bubble && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign OutValid  = vld_p1;
  assign OutCtrl   = ctrl_p1;
  assign OutRsData = rs_data_p1;
  assign OutRtData = rt_data_p1;
  assign OutImm    = imm_p1;
  assign OutPC     = pc_p1;
  assign OutRdAddr = rd_p1;
  assign OutRsAddr = rs_p1;
  assign OutRtAddr = rt_p1;
  assign OutShamt  = shamt_p1;
  assign StallCnt  = stall_cnt;

endmodule
